// File: rtl/af_sv_bit_serializer.sv
// rtl/af_sv_bit_serializer.sv - framed parallel-to-serial driver for af_sv_if.bit_a
// One start bit, DATA_W data bits, one stop bit, each held CLKS_PER_BIT clocks.
module af_sv_bit_serializer #(
  parameter int   DATA_W       = 8,
  parameter int   CLKS_PER_BIT = 4,
  parameter bit   LSB_FIRST    = 1'b1,
  parameter logic IDLE_LVL     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              bit_a,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     clk_cnt, clk_cnt_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              bit_nxt;
  logic              period_end;

  assign period_end = (clk_cnt == CNT_LAST);
  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      bit_a   <= IDLE_LVL;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      bit_a   <= bit_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    frame_done  = 1'b0;
    bit_nxt     = IDLE_LVL;

    case (state)
      IDLE: begin
        if (in_valid) begin
          shreg_nxt   = in_data;
          state_nxt   = START;
          clk_cnt_nxt = '0;
        end
      end
      START: begin
        if (period_end) begin
          state_nxt   = DATA;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (period_end) begin
          clk_cnt_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shreg_nxt   = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        frame_done = period_end;
        if (period_end) begin
          state_nxt   = IDLE;
          clk_cnt_nxt = '0;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The line register is loaded from the upcoming state so it tracks state with no extra lag.
    case (state_nxt)
      START:   bit_nxt = ~IDLE_LVL;
      DATA:    bit_nxt = LSB_FIRST ? shreg_nxt[0] : shreg_nxt[DATA_W-1];
      default: bit_nxt = IDLE_LVL;
    endcase
  end

endmodule

// File: tb/tb_af_sv_bit_serializer.sv
// tb/tb_af_sv_bit_serializer.sv - self-checking bench for af_sv_bit_serializer
// Compares the serial line against a frame model built from bit positions.
module tb_af_sv_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_valid, a_ready, a_bit, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_valid, b_ready, b_bit, b_busy, b_done;
  logic [3:0] b_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  af_sv_bit_serializer dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .bit_a(a_bit), .busy(a_busy), .frame_done(a_done)
  );

  af_sv_bit_serializer #(.DATA_W(4), .CLKS_PER_BIT(1), .LSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .bit_a(b_bit), .busy(b_busy), .frame_done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level k clocks after the handshake: bit slot k/cpb is start, data or stop.
  function automatic logic ref_bit(input logic [31:0] w, input int k, input int dw,
                                   input int cpb, input bit lsb);
    int slot;
    slot = k / cpb;
    if (slot == 0) return 1'b0;
    if (slot == dw + 1) return 1'b1;
    return lsb ? w[slot-1] : w[dw-slot];
  endfunction

  task automatic send_a(input logic [7:0] word, input bit keep, input logic [7:0] nxt,
                        input bit noise, output int hs);
    int waited;
    waited  = 0;
    a_valid = 1'b1;
    a_data  = word;
    while (!a_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("a_hs_wait", 32'(waited < 200), 32'(1));
    @(posedge clk);
    @(negedge clk);
    hs      = cyc;
    a_valid = keep;
    a_data  = nxt;
    for (int k = 0; k < 40; k++) begin
      if (noise && k == 12) begin
        a_valid = 1'b1;
        a_data  = 8'h55;
      end
      if (noise && k == 14) a_valid = 1'b0;
      check($sformatf("a_bit[%0d] w=%0h", k, word), 32'(a_bit), 32'(ref_bit(32'(word), k, 8, 4, 1'b1)));
      check($sformatf("a_done[%0d]", k), 32'(a_done), 32'(k == 39));
      check($sformatf("a_ready[%0d]", k), 32'(a_ready), 32'(0));
      check($sformatf("a_busy[%0d]", k), 32'(a_busy), 32'(1));
      @(negedge clk);
    end
    check("a_ready_end", 32'(a_ready), 32'(1));
    check("a_idle_lvl", 32'(a_bit), 32'(1));
    check("a_done_end", 32'(a_done), 32'(0));
  endtask

  task automatic send_b(input logic [3:0] word);
    int waited;
    waited  = 0;
    b_valid = 1'b1;
    b_data  = word;
    while (!b_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("b_hs_wait", 32'(waited < 50), 32'(1));
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("b_bit[%0d] w=%0h", k, word), 32'(b_bit), 32'(ref_bit(32'(word), k, 4, 1, 1'b0)));
      check($sformatf("b_done[%0d]", k), 32'(b_done), 32'(k == 5));
      @(negedge clk);
    end
    check("b_ready_end", 32'(b_ready), 32'(1));
  endtask

  initial begin
    int h1, h2, seen;
    rst_n   = 1'b1;
    a_valid = 1'b0;
    a_data  = '0;
    b_valid = 1'b0;
    b_data  = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_bit", 32'(a_bit), 32'(1));
    check("rst_ready", 32'(a_ready), 32'(1));
    check("rst_busy", 32'(a_busy), 32'(0));
    check("rst_done", 32'(a_done), 32'(0));
    check("rst_b_ready", 32'(b_ready), 32'(1));
    check("rst_b_bit", 32'(b_bit), 32'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_a(8'hA5, 1'b0, 8'h00, 1'b0, h1);

    send_a(8'hFF, 1'b1, 8'h00, 1'b0, h1);
    send_a(8'h00, 1'b0, 8'h00, 1'b0, h2);
    check("b2b_spacing", 32'(h2 - h1), 32'(41));

    send_a(8'hC3, 1'b0, 8'h00, 1'b1, h1);

    // Abort 8'h0F during data bit 3 with an asynchronous reset.
    a_valid = 1'b1;
    a_data  = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_bit3", 32'(a_bit), 32'(1));
    check("mid_busy", 32'(a_busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bit", 32'(a_bit), 32'(1));
    check("mid_rst_ready", 32'(a_ready), 32'(1));
    check("mid_rst_busy", 32'(a_busy), 32'(0));
    check("mid_rst_done", 32'(a_done), 32'(0));
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (a_done) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_done || !a_ready || a_bit !== 1'b1) seen++;
    end
    check("mid_rst_quiet", 32'(seen), 32'(0));
    send_a(8'h3C, 1'b0, 8'h00, 1'b0, h1);

    for (int i = 0; i < 6; i++)
      send_a(8'($urandom), 1'b0, 8'h00, 1'($urandom_range(0, 1)), h1);

    send_b(4'b1001);
    for (int i = 0; i < 5; i++) send_b(4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
